fifo_push_arbiter: RTL and testbench

Round-robin push-side arbiter that shares one `synch_fifo` write port between `N_REQ` requesters. Each requester presents a word with `req` and is acknowledged with `ack` in the cycle its word is pushed. A granted requester may hold the port for up to `MAX_BURST` consecutive pushes. The block sits directly in front of the FIFO's `push_en`/`fifo_din` inputs and consumes its `full` flag.

---
 rtl/fifo_push_arbiter_pkg.sv | 26 ++
 rtl/fifo_push_arbiter_if.sv | 31 +++
 rtl/fifo_push_arbiter_rr_pick.sv | 31 +++
 rtl/fifo_push_arbiter.sv | 112 +++++++++++
 tb/tb_fifo_push_arbiter.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_push_arbiter_pkg.sv
// Shared types and width helpers for the FIFO push arbiter and its picker.
// FIFO_ARB_SRC_TAG_EN widens the FIFO word by a source tag.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    function automatic int tag_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_w(input int max_burst);
        return $clog2(max_burst) + 1;
    endfunction

    function automatic int din_w(input int data_w, input int n);
`ifdef FIFO_ARB_SRC_TAG_EN
        return data_w + tag_w(n);
`else
        return data_w;
`endif
    endfunction

endpackage

// File: rtl/fifo_push_arbiter_if.sv
// Requester-side and FIFO-side signals of the push arbiter.
// fifo_din carries a source tag in its MSBs when FIFO_ARB_SRC_TAG_EN is defined.
interface fifo_push_arbiter_if
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 32
);
    localparam int OWN_W = tag_w(N_REQ);
    localparam int DIN_W = din_w(DATA_W, N_REQ);

    logic [N_REQ-1:0]        req;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        ack;
    logic                    fifo_full;
    logic                    fifo_push_en;
    logic [DIN_W-1:0]        fifo_din;
    logic                    busy;
    logic [OWN_W-1:0]        cur_owner;

    modport master (
        input  req, req_data, fifo_full,
        output ack, fifo_push_en, fifo_din, busy, cur_owner
    );

    modport slave (
        output req, req_data, fifo_full,
        input  ack, fifo_push_en, fifo_din, busy, cur_owner
    );

endinterface

// File: rtl/fifo_push_arbiter_rr_pick.sv
// Rotating-base priority picker: first set request at or after rr_ptr, modulo N.
// Purely combinational so pop-side schedulers can reuse it.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = tag_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] rr_ptr,
    output logic          any,
    output logic [IW-1:0] winner
);

    always_comb begin
        int          idx;
        logic [IW-1:0] idx_t;
        any    = |req;
        winner = '0;
        idx    = 0;
        idx_t  = '0;
        // Walk from the farthest offset down so the nearest requester wins last.
        for (int k = N - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= N) idx = idx - N;
            idx_t = IW'(idx);
            if (req[idx_t]) winner = idx_t;
        end
    end

endmodule

// File: rtl/fifo_push_arbiter.sv
// Round-robin push arbiter sharing one FIFO write port among N_REQ requesters,
// with bursts of up to MAX_BURST pushes per grant. FIFO_ARB_SRC_TAG_EN prepends the source index.
module fifo_push_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input logic               clk,
    input logic               rst,
    fifo_push_arbiter_if.master bus
);

    localparam int OWN_W = tag_w(N_REQ);
    localparam int CNT_W = cnt_w(MAX_BURST);

    arb_state_e       state;
    logic [OWN_W-1:0] owner;
    logic [OWN_W-1:0] rr_ptr;
    logic [CNT_W-1:0] burst_cnt;
    logic [CNT_W-1:0] burst_nxt;
    logic             busy_q;

    logic             any;
    logic [OWN_W-1:0] winner;
    logic [OWN_W-1:0] sel;
    logic             xfer;
    logic [DATA_W-1:0] data_sel;

    function automatic logic [OWN_W-1:0] next_ptr(input logic [OWN_W-1:0] p);
        return (int'(p) == N_REQ - 1) ? '0 : p + 1'b1;
    endfunction

    rr_pick #(
        .N  (N_REQ),
        .IW (OWN_W)
    ) u_pick (
        .req    (bus.req),
        .rr_ptr (rr_ptr),
        .any    (any),
        .winner (winner)
    );

    // Zero-latency grant path; the current full flag gates every push.
    always_comb begin
        sel  = (state == LOCK) ? owner : winner;
        xfer = 1'b0;
        if (!rst && !bus.fifo_full)
            xfer = (state == LOCK) ? bus.req[owner] : any;
        data_sel  = bus.req_data[sel*DATA_W +: DATA_W];
        burst_nxt = burst_cnt + 1'b1;
    end

    assign bus.fifo_push_en = xfer;
    assign bus.ack          = xfer ? (N_REQ'(1) << sel) : '0;
`ifdef FIFO_ARB_SRC_TAG_EN
    assign bus.fifo_din     = {sel, data_sel};
`else
    assign bus.fifo_din     = data_sel;
`endif
    assign bus.busy         = busy_q;
    assign bus.cur_owner    = owner;

    // Owner is cleared on release so it doubles as the registered cur_owner.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= '0;
            burst_cnt <= '0;
            rr_ptr    <= '0;
            busy_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (xfer) begin
                        if (MAX_BURST == 1) begin
                            rr_ptr <= next_ptr(winner);
                        end else begin
                            state     <= LOCK;
                            owner     <= winner;
                            burst_cnt <= CNT_W'(1);
                            busy_q    <= 1'b1;
                        end
                    end
                end
                LOCK: begin
                    if (!bus.req[owner]) begin
                        state  <= IDLE;
                        rr_ptr <= next_ptr(owner);
                        owner  <= '0;
                        busy_q <= 1'b0;
                    end else if (xfer) begin
                        burst_cnt <= burst_nxt;
                        if (burst_nxt == CNT_W'(MAX_BURST)) begin
                            state  <= IDLE;
                            rr_ptr <= next_ptr(owner);
                            owner  <= '0;
                            busy_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    owner  <= '0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Scoreboard bench for fifo_push_arbiter: one instance with MAX_BURST=4, one with MAX_BURST=1.
module tb_fifo_push_arbiter;
    import fifo_arb_pkg::*;

    localparam int N     = 4;
    localparam int DW    = 32;
    localparam int OW    = tag_w(N);
    localparam int DIN_W = din_w(DW, N);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fifo_push_arbiter_if #(.N_REQ(N), .DATA_W(DW)) bus0 ();
    fifo_push_arbiter_if #(.N_REQ(N), .DATA_W(DW)) bus1 ();

    fifo_push_arbiter #(.N_REQ(N), .DATA_W(DW), .MAX_BURST(4)) dut0 (
        .clk (clk), .rst (rst), .bus (bus0)
    );
    fifo_push_arbiter #(.N_REQ(N), .DATA_W(DW), .MAX_BURST(1)) dut1 (
        .clk (clk), .rst (rst), .bus (bus1)
    );

    typedef struct {
        int               port;
        logic [DIN_W-1:0] din;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cnt0[N], cnt1[N], ecnt0[N], ecnt1[N];
    logic pe0_s, pe1_s;
    logic [N-1:0] ack0_s, ack1_s;

    function automatic logic [DW-1:0] word(input int dut, input int p, input int n);
        return {8'(160 + dut*16 + p), 24'(n)};
    endfunction

    function automatic logic [DIN_W-1:0] exp_din(input int p, input logic [DW-1:0] d);
`ifdef FIFO_ARB_SRC_TAG_EN
        return {OW'(p), d};
`else
        return d;
`endif
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp_v);
        end
    endtask

    task automatic refresh();
        for (int i = 0; i < N; i++) begin
            bus0.req_data[i*DW +: DW] = word(0, i, cnt0[i]);
            bus1.req_data[i*DW +: DW] = word(1, i, cnt1[i]);
        end
    endtask

    // One clock: sample at negedge, then let requesters advance on their acks.
    task automatic step();
        logic [N-1:0] a0, a1;
        @(negedge clk);
        a0 = bus0.ack;  a1 = bus1.ack;
        ack0_s = a0;    ack1_s = a1;
        pe0_s = bus0.fifo_push_en;
        pe1_s = bus1.fifo_push_en;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (a0[i]) cnt0[i]++;
            if (a1[i]) cnt1[i]++;
        end
        refresh();
    endtask

    task automatic exp0(input int p);
        q0.push_back('{p, exp_din(p, word(0, p, ecnt0[p]))});
        ecnt0[p]++;
    endtask

    task automatic exp1(input int p);
        q1.push_back('{p, exp_din(p, word(1, p, ecnt1[p]))});
        ecnt1[p]++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        check("rst_push_en0", 64'(pe0_s), 64'd0);
        check("rst_push_en1", 64'(pe1_s), 64'd0);
        rst = 1'b0;
    endtask

    // Monitor: pops one expectation per observed push.
    always @(negedge clk) begin
        exp_t e;
        if (bus0.fifo_push_en === 1'b1) begin
            if (q0.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL dut0_unexpected_push: got ack %0h, expected no push", bus0.ack);
            end else begin
                e = q0.pop_front();
                check("dut0_ack", 64'(bus0.ack), 64'(N'(1) << e.port));
                check("dut0_din", 64'(bus0.fifo_din), 64'(e.din));
            end
        end
        if (bus1.fifo_push_en === 1'b1) begin
            if (q1.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL dut1_unexpected_push: got ack %0h, expected no push", bus1.ack);
            end else begin
                e = q1.pop_front();
                check("dut1_ack", 64'(bus1.ack), 64'(N'(1) << e.port));
                check("dut1_din", 64'(bus1.fifo_din), 64'(e.din));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus0.req = '0; bus0.fifo_full = 1'b0;
        bus1.req = '0; bus1.fifo_full = 1'b0;
        for (int i = 0; i < N; i++) begin
            cnt0[i] = 0; cnt1[i] = 0; ecnt0[i] = 0; ecnt1[i] = 0;
        end
        refresh();

        // Reset with all requests raised: nothing may be acked.
        bus0.req = 4'b1111;
        bus1.req = 4'b1111;
        step();
        step();
        check("rst_ack0", 64'(ack0_s), 64'd0);
        check("rst_ack1", 64'(ack1_s), 64'd0);
        check("rst_pe0", 64'(pe0_s), 64'd0);
        rst = 1'b0;
        bus1.req = '0;
        check("rst_busy", 64'(bus0.busy), 64'd0);
        check("rst_owner", 64'(bus0.cur_owner), 64'd0);

        // Full contention: 0x4,1x4,2x4,3x4 then wrap to 0, no gaps.
        bus0.req = 4'b1111;
        for (int k = 0; k < 17; k++) begin
            exp0((k / 4) % 4);
            step();
            if (k == 0) check("t1_busy_lock", 64'(bus0.busy), 64'd1);
            if (k == 3) check("t1_busy_release", 64'(bus0.busy), 64'd0);
            if (k == 4) check("t1_owner1", 64'(bus0.cur_owner), 64'd1);
            if (k == 12) check("t1_owner3", 64'(bus0.cur_owner), 64'd3);
        end
        bus0.req = '0;
        step();
        check("t1_drop_pe", 64'(pe0_s), 64'd0);

        // Owner 0 drops after 2 pushes: one empty cycle, then port 2.
        bus0.req = '0;
        do_reset();
        bus0.req = 4'b0101;
        exp0(0); step();
        exp0(0); step();
        bus0.req = 4'b0100;
        step();
        check("t2_gap_pe", 64'(pe0_s), 64'd0);
        exp0(2); step();
        check("t2_owner2", 64'(bus0.cur_owner), 64'd2);
        bus0.req = '0;
        step();

        // Owner 1 stalled by full mid-burst; burst resumes with 2 pushes.
        do_reset();
        bus0.req = 4'b0010;
        exp0(1); step();
        exp0(1); step();
        bus0.req = 4'b1111;
        bus0.fifo_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            check("t3_full_pe", 64'(pe0_s), 64'd0);
        end
        check("t3_busy", 64'(bus0.busy), 64'd1);
        check("t3_owner", 64'(bus0.cur_owner), 64'd1);
        bus0.fifo_full = 1'b0;
        exp0(1); step();
        exp0(1); step();
        exp0(2); step();
        check("t3_handover", 64'(bus0.cur_owner), 64'd2);
        bus0.req = '0;
        step();

        // Reset mid-burst of owner 1: arbitration restarts at port 0.
        do_reset();
        bus0.req = 4'b0010;
        exp0(1); step();
        bus0.req = 4'b1111;
        exp0(1); step();
        rst = 1'b1;
        step();
        check("t5_rst_ack", 64'(ack0_s), 64'd0);
        check("t5_rst_pe", 64'(pe0_s), 64'd0);
        rst = 1'b0;
        check("t5_busy", 64'(bus0.busy), 64'd0);
        check("t5_owner", 64'(bus0.cur_owner), 64'd0);
        exp0(0); step();
        check("t5_restart_owner", 64'(bus0.cur_owner), 64'd0);
        check("t5_restart_busy", 64'(bus0.busy), 64'd1);
        bus0.req = '0;
        step();

        // MAX_BURST=1: prime rr_ptr to 3, then alternate 3,0,3,0.
        do_reset();
        bus1.req = 4'b0100;
        exp1(2); step();
        check("t4_no_lock", 64'(bus1.busy), 64'd0);
        bus1.req = 4'b1001;
        exp1(3); step();
        exp1(0); step();
        exp1(3); step();
        exp1(0); step();
        bus1.req = '0;
        step();

        // Fixed data word on port 2 (tagged when the tag option is built in).
        do_reset();
        bus0.req = 4'b0100;
        bus0.req_data[2*DW +: DW] = 32'hDEADBEEF;
        q0.push_back('{2, exp_din(2, 32'hDEADBEEF)});
        step();
        bus0.req = '0;
        step();
        step();

        check("q0_drained", 64'(q0.size()), 64'd0);
        check("q1_drained", 64'(q1.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
